// File: rtl/iter_ctrl.sv
// Iteration sequencer: loads an external 2-bit pass counter, runs WAIT_CYC
// processing cycles per pass, steps the counter until carry-out, then holds done.
module iter_ctrl #(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] init_val,
  input  logic       ack,
  input  logic       cnt_cout,
  output logic       cnt_ld,
  output logic [1:0] cnt_ld_val,
  output logic       cnt_inc,
  output logic       dp_ld,
  output logic       dp_en,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] WLAST = 4'(WAIT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    PROC,
    STEP,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] iv_q;
  logic [1:0] iv_nxt;
  logic [3:0] wcnt;
  logic [3:0] wcnt_nxt;
  logic       wlast;

  assign wlast = (wcnt == WLAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      iv_q  <= 2'd0;
      wcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      iv_q  <= iv_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Outputs depend on state and iv_q only; inputs steer next state alone.
  always_comb begin
    state_nxt  = state;
    iv_nxt     = iv_q;
    wcnt_nxt   = wcnt;
    cnt_ld     = 1'b0;
    cnt_ld_val = 2'd0;
    cnt_inc    = 1'b0;
    dp_ld      = 1'b0;
    dp_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          iv_nxt    = init_val;
          state_nxt = INIT;
        end
      end
      INIT: begin
        cnt_ld     = 1'b1;
        dp_ld      = 1'b1;
        cnt_ld_val = iv_q;
        busy       = 1'b1;
        wcnt_nxt   = 4'd0;
        state_nxt  = PROC;
      end
      PROC: begin
        dp_en = 1'b1;
        busy  = 1'b1;
        if (wlast) begin
          wcnt_nxt  = 4'd0;
          state_nxt = cnt_cout ? DONE : STEP;
        end else begin
          wcnt_nxt = wcnt + 4'd1;
        end
      end
      STEP: begin
        cnt_inc   = 1'b1;
        busy      = 1'b1;
        wcnt_nxt  = 4'd0;
        state_nxt = PROC;
      end
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
        if (ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/iter_ctrl.md
ITER_CTRL -- requirements
Module: iter_ctrl

Interface
REQ-001 The block SHALL have parameter: WAIT_CYC, default 1, processing cycles per iteration (legal range 1..15; 0 illegal).
REQ-002 The block SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port: start  input  1  request a run; sampled only in IDLE.
REQ-005 The block SHALL have port: init_val  input  2  initial iteration-counter value; captured with start.
REQ-006 The block SHALL have port: ack  input  1  downstream acceptance of done.
REQ-007 The block SHALL have port: cnt_cout  input  1  iteration-counter carry-out (high when counter value = 3).
REQ-008 The block SHALL have port: cnt_ld  output  1  iteration-counter load strobe.
REQ-009 The block SHALL have port: cnt_ld_val  output  2  iteration-counter load value.
REQ-010 The block SHALL have port: cnt_inc  output  1  iteration-counter increment strobe.
REQ-011 The block SHALL have port: dp_ld  output  1  datapath operand-load strobe.
REQ-012 The block SHALL have port: dp_en  output  1  datapath processing enable.
REQ-013 The block SHALL have port: busy  output  1  high in every state except IDLE.
REQ-014 The block SHALL have port: done  output  1  run complete; held until ack.

Function
REQ-015 The block SHALL implement states IDLE, INIT, PROC, STEP, DONE; all outputs SHALL be Moore-decoded from state (plus registers), never combinationally from inputs.
REQ-016 IDLE: all strobes 0, busy 0; start=1 SHALL capture init_val into an internal register and move to INIT at that edge.
REQ-017 INIT (exactly 1 cycle): cnt_ld=1, dp_ld=1, cnt_ld_val=captured init_val; next state PROC; wait counter cleared to 0.
REQ-018 PROC: dp_en=1; wait counter increments each cycle; after WAIT_CYC cycles in PROC, next state SHALL be DONE if cnt_cout=1, else STEP.
REQ-019 cnt_cout SHALL be sampled only on the final PROC cycle of each pass; ignored in all other states/cycles.
REQ-020 STEP (exactly 1 cycle): cnt_inc=1; wait counter cleared; next state PROC.
REQ-021 DONE: done=1, busy=1; ack=1 SHALL move to IDLE at that edge; ack=0 holds DONE indefinitely.
REQ-022 Pass count P SHALL equal 4 - init_val (init_val=0 -> 4 passes; init_val=3 -> 1 pass).
REQ-023 done SHALL first be high N = 1 + P*WAIT_CYC + (P-1) edges after the edge that samples start.
REQ-024 cnt_ld_val SHALL be 0 outside INIT; cnt_ld, cnt_inc never high in the same cycle.
REQ-025 start while busy=1 SHALL be ignored and not queued; start high on the edge DONE->IDLE SHALL be ignored (must be high while in IDLE).
REQ-026 ack outside DONE SHALL be ignored.
REQ-027 Wait counter SHALL be 4 bits, never exceed WAIT_CYC-1, and never wrap.

Reset
REQ-028 rst=1 on a rising edge SHALL force IDLE, clear captured init_val and wait counter; all outputs 0 in the following cycle.
REQ-029 rst SHALL take priority over start, ack and every state transition, including mid-PROC and mid-DONE.
REQ-030 The block SHALL NOT drive the iteration-counter reset; a stale counter value after mid-run reset SHALL be overwritten by the next INIT load.

Verification
REQ-031 Bench: rst, start=1 with init_val=0, WAIT_CYC=1, ack held 1 -> cnt_ld at edge+1, 4 PROC cycles, 3 cnt_inc pulses, done high 8 edges after start, IDLE next cycle.
REQ-032 Bench: init_val=3, WAIT_CYC=3 -> 1 pass, zero cnt_inc, 3 dp_en cycles, done after 4 edges.
REQ-033 Bench: ack held 0 for 10 cycles in DONE -> done stays 1, busy 1; ack=1 -> IDLE, busy 0 next cycle.
REQ-034 Bench: start pulsed during PROC and on DONE->IDLE edge -> no new run; second start in IDLE -> normal run.
REQ-035 Bench: rst asserted in second PROC pass -> all outputs 0 next cycle; new start with init_val=2 -> cnt_ld_val=2, 2 passes, done after 1+2+1=4 edges (WAIT_CYC=1).
